// File: rtl/hex_display_scanner.sv
// Eight-digit multiplexed hex display driver with a tear-free shadow word and anode guard intervals.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 7 always shown).
module hex_display_scanner #(
    parameter int CLK_DIV      = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        enable,
    input  logic [31:0] x_in,
    input  logic        load,
    output logic [31:0] word_out,
    output logic [2:0]  byte_select,
    input  logic [3:0]  nibble,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        frame_done
);

    localparam int MAX_CNT = (CLK_DIV > GUARD_CYCLES) ? CLK_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DRIVE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         digit_q, digit_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        pend_q, pend_d;
    logic               pv_q, pv_d;
    logic [6:0]         seg_q, seg_d;
    logic [7:0]         anodes_q, anodes_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_start;
    logic               blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (digit_q != 3'd7) &&
                   ((word_q >> (5'd28 - {digit_q, 2'b00})) == 32'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        digit_d     = digit_q;
        seg_d       = seg_q;
        word_d      = word_q;
        pend_d      = pend_q;
        pv_d        = pv_q;
        frame_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                digit_d = 3'd0;
                if (enable) begin
                    state_d     = ST_GUARD;
                    frame_start = 1'b1;
                end
            end
            ST_GUARD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    digit_d = 3'd0;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    seg_d   = blank ? 7'h7F : hex_to_seg(nibble);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    digit_d = 3'd0;
                end else if (cnt_q == DRIVE_LAST) begin
                    state_d     = ST_GUARD;
                    cnt_d       = '0;
                    digit_d     = digit_q + 3'd1;
                    frame_start = (digit_q == 3'd7);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                digit_d = 3'd0;
            end
        endcase

        if (state_d == ST_IDLE) begin
            seg_d = 7'h7F;
        end

        // The shadow word only changes at the start of a frame; a coincident load bypasses pending.
        if (frame_start) begin
            if (load) begin
                word_d = x_in;
            end else if (pv_q) begin
                word_d = pend_q;
            end
            pv_d = 1'b0;
        end else if (load) begin
            pend_d = x_in;
            pv_d   = 1'b1;
        end

        anodes_d     = (state_d == ST_DRIVE) ? ~(8'h80 >> digit_d) : 8'hFF;
        frame_done_d = (state_d == ST_DRIVE) && (digit_d == 3'd7) && (cnt_d == DRIVE_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            digit_q      <= 3'd0;
            seg_q        <= 7'h7F;
            word_q       <= 32'd0;
            pend_q       <= 32'd0;
            pv_q         <= 1'b0;
            anodes_q     <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            seg_q        <= seg_d;
            word_q       <= word_d;
            pend_q       <= pend_d;
            pv_q         <= pv_d;
            anodes_q     <= anodes_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign word_out    = word_q;
    assign byte_select = digit_q;
    assign anodes      = anodes_q;
    assign segments    = seg_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: frame-position reference model plus directed literal checks.
module tb_hex_display_scanner;

    localparam int D     = 4;
    localparam int G     = 1;
    localparam int P     = G + D;
    localparam int FRAME = 8 * P;

    logic        clk = 1'b0;
    logic        rstb;
    logic        enable;
    logic [31:0] x_in;
    logic        load;
    logic [31:0] word_out;
    logic [2:0]  byte_select;
    logic [3:0]  nibble;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: scan position within the frame plus shadow/pending words.
    bit          m_run  = 1'b0;
    int          m_pos  = 0;
    logic [31:0] m_word = 32'd0;
    logic [31:0] m_pend = 32'd0;
    bit          m_pv   = 1'b0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] lit_an  [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [6:0] lit_seg [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
`ifdef LEADING_ZERO_BLANK_EN
    logic [6:0] lz_seg  [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40};
`else
    logic [6:0] lz_seg  [8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40};
`endif

    hex_display_scanner #(.CLK_DIV(D), .GUARD_CYCLES(G)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .enable      (enable),
        .x_in        (x_in),
        .load        (load),
        .word_out    (word_out),
        .byte_select (byte_select),
        .nibble      (nibble),
        .anodes      (anodes),
        .segments    (segments),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Combinational nibble mux beside the scanner.
    always_comb begin
        nibble = word_out[(28 - 4 * int'(byte_select)) +: 4];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] w, input int d);
        logic [3:0] n;
        n = w[(28 - 4 * d) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (d < 7 && (w >> (28 - 4 * d)) == 32'd0) return 7'h7F;
`endif
        return dec_tab[n];
    endfunction

    task automatic model_step();
        bit entry;
        entry = 1'b0;
        if (!rstb) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_word = 32'd0;
            m_pend = 32'd0;
            m_pv   = 1'b0;
        end else begin
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1;
                    m_pos = 0;
                    entry = 1'b1;
                end
            end else if (!enable) begin
                m_run = 1'b0;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                entry = (m_pos == 0);
            end
            if (entry) begin
                if (load) m_word = x_in;
                else if (m_pv) m_word = m_pend;
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = x_in;
                m_pv   = 1'b1;
            end
        end
    endtask

    task automatic model_compare();
        int  dig;
        int  ph;
        bit  on;
        logic [7:0] an_exp;
        dig    = m_pos / P;
        ph     = m_pos % P;
        on     = m_run && (ph >= G);
        an_exp = on ? ~(8'h80 >> dig) : 8'hFF;
        chk("m_word_out", word_out, m_word);
        chk("m_byte_select", 32'(byte_select), m_run ? 32'(dig) : 32'd0);
        chk("m_anodes", 32'(anodes), 32'(an_exp));
        chk("m_frame_done", 32'(frame_done), 32'(on && dig == 7 && ph == P - 1));
        if (on) chk("m_segments", 32'(segments), 32'(exp_seg(m_word, dig)));
        else if (!m_run) chk("m_segments_idle", 32'(segments), 32'h7F);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            model_compare();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstb   = 1'b0;
        enable = 1'b1;
        load   = 1'b1;
        x_in   = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_anodes", 32'(anodes), 32'hFF);
            chk("rst_segments", 32'(segments), 32'h7F);
            chk("rst_word", word_out, 32'h0);
            chk("rst_frame_done", 32'(frame_done), 32'h0);
        end

        // Full frame of 0x12345678
        rstb   = 1'b1;
        enable = 1'b0;
        x_in   = 32'h12345678;
        tick(1);
        load   = 1'b0;
        enable = 1'b1;
        tick(1);
        chk("ff_word", word_out, 32'h12345678);
        chk("ff_guard_anodes", 32'(anodes), 32'hFF);
        tick(1);
        for (int k = 0; k < 8; k++) begin
            chk("ff_anodes", 32'(anodes), 32'(lit_an[k]));
            chk("ff_segments", 32'(segments), 32'(lit_seg[k]));
            if (k < 7) tick(5);
        end
        tick(3);
        chk("ff_frame_done", 32'(frame_done), 32'h1);
        tick(1);
        chk("ff_frame_done_clear", 32'(frame_done), 32'h0);
        chk("ff_wrap_guard", 32'(anodes), 32'hFF);

        // Load during digit 3 must not tear the current frame
        tick(16);
        load = 1'b1;
        x_in = 32'hAAAAAAAA;
        tick(1);
        load = 1'b0;
        chk("tear_word_hold", word_out, 32'h12345678);
        for (int k = 3; k < 8; k++) begin
            chk("tear_segments", 32'(segments), 32'(lit_seg[k]));
            if (k < 7) tick(5);
        end
        tick(3);
        chk("tear_word_new", word_out, 32'hAAAAAAAA);
        tick(1);
        chk("tear_digit0", 32'(segments), 32'h08);

        // Load coinciding with the frame-start edge
        tick(38);
        load = 1'b1;
        x_in = 32'hFFFFFFFF;
        tick(1);
        load = 1'b0;
        chk("simul_word", word_out, 32'hFFFFFFFF);
        tick(1);
        chk("simul_digit0", 32'(segments), 32'h0E);

        // Enable dropped during digit 5 drive
        tick(26);
        enable = 1'b0;
        tick(1);
        chk("drop_anodes", 32'(anodes), 32'hFF);
        chk("drop_segments", 32'(segments), 32'h7F);
        tick(3);
        enable = 1'b1;
        tick(1);
        chk("restart_guard", 32'(anodes), 32'hFF);
        tick(1);
        chk("restart_anodes", 32'(anodes), 32'h7F);
        chk("restart_select", 32'(byte_select), 32'h0);
        chk("restart_segments", 32'(segments), 32'h0E);

        // Mostly-zero word: leading digits
        load = 1'b1;
        x_in = 32'h000000A0;
        tick(1);
        load = 1'b0;
        tick(38);
        chk("lz_word", word_out, 32'h000000A0);
        for (int k = 0; k < 8; k++) begin
            tick(k == 0 ? 1 : 5);
            chk("lz_anodes", 32'(anodes), 32'(lit_an[k]));
            chk("lz_segments", 32'(segments), 32'(lz_seg[k]));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rstb   = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 149) != 0);
            load   = ($urandom_range(0, 24) == 0);
            x_in   = $urandom() >> $urandom_range(0, 31);
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexes a 32-bit word onto an 8-digit common-anode seven-segment display. The block owns the `half_byte_mux` that sits beside it in the debug display path. It holds a tear-free shadow copy of the word and drives that copy plus `byte_select` into the mux. It then registers the returned nibble through a hex-to-segment decoder and drives one anode at a time, with a blanking guard interval between digits to suppress ghosting.

## Interface
- `CLK_DIV`, 1000: clock cycles each digit is driven (DRIVE phase); minimum 1.
- `GUARD_CYCLES`, 2: clock cycles all anodes are off before each digit (GUARD phase); minimum 1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rstb` in 1: reset, synchronous and active-low.
- `enable` in 1: scan enable; low forces IDLE with the display dark.
- `x_in` in 32: word to display.
- `load` in 1: capture `x_in` into the pending register this cycle.
- `word_out` out 32: shadow word, wired to mux `x`.
- `byte_select` out 3: digit index, wired to mux `byte_select`; 0 selects `[31:28]`, the leftmost digit.
- `nibble` in 4: mux output `y`.
- `anodes` out 8: active-low digit enables; `anodes[7]` is the leftmost digit (`byte_select` 0), so the asserted bit is `7 - byte_select`.
- `segments` out 7: active-low `{g,f,e,d,c,b,a}`.
- `frame_done` out 1: one-cycle pulse at the end of digit 7's DRIVE phase.

## Operation
- **Outputs:** all outputs are registered.
- **Reset values:** state IDLE, `byte_select`=0, `anodes`=8'hFF, `segments`=7'h7F, `word_out`=0, pending=0, pending_valid=0, `frame_done`=0, counters=0.
- **IDLE:** `anodes`=8'hFF and `segments`=7'h7F. If `enable`=1, go to GUARD with digit 0.
- **GUARD:**
  - `anodes`=8'hFF and `byte_select`=digit; the phase lasts `GUARD_CYCLES` cycles.
  - On its last cycle, the segment register loads decode(`nibble`). The mux is combinational, so `nibble` reflects the current `word_out` and `byte_select`.
- **DRIVE:**
  - `anodes` has only bit `7-digit` low, and `segments` = segment register; the phase lasts `CLK_DIV` cycles.
  - On its last cycle, digit increments modulo 8 (7 wraps to 0) and the state goes to GUARD.
  - If the digit was 7, `frame_done`=1 for that cycle.
- **Shadow update:** on every entry into GUARD for digit 0 (from IDLE or from wrap), if pending_valid=1, then `word_out` ← pending and pending_valid ← 0. `word_out` never changes mid-frame.
- **Load:**
  - `load`=1 sets pending ← `x_in` and pending_valid ← 1; the latest load wins.
  - If `load` coincides with the shadow-update edge, the new `x_in` bypasses pending and goes straight to `word_out`, and pending_valid ends at 0.
- **Enable deasserted** in GUARD or DRIVE: the next state is IDLE and `anodes`=8'hFF from the next cycle. The digit counter and phase counter are cleared, and `word_out` is retained.
- **Reset mid-scan:** all reset values apply on the next edge, and any pending load is lost.
- **Decoder (active-low):**
  - digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - letters: A=08, b=03, C=46, d=21, E=06, F=0E
- **Counters:** one phase counter of width $clog2(max(`CLK_DIV`,`GUARD_CYCLES`)+1) and one 3-bit digit counter.

## Timing
- Per-digit period is `GUARD_CYCLES`+`CLK_DIV` cycles; one frame is 8× that.
- From an `enable` rise sampled at edge N:
  - GUARD starts at N+1.
  - The first digit-0 anode is asserted at N+1+`GUARD_CYCLES`.
- Load to visible:
  - best case is the next digit-0 GUARD entry;
  - worst case is one full frame plus one cycle.
- Anodes are never asserted for two digits simultaneously, and at least `GUARD_CYCLES` cycles separate consecutive anode assertions.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined:**
  - In GUARD, the segment register loads 7'h7F instead of decode(`nibble`) when digit<7 and `word_out` nibbles 0..digit are all zero.
  - Anode sequencing is unchanged.
  - Digit 7 is always shown, so a word of 0 displays a single "0".
- **Not defined:** every digit shows its hex value, including leading zeros.

## Test plan
- **Reset:** hold `rstb`=0 for 3 cycles with `enable`=1 and `load`=1 → `anodes`=FF, `segments`=7F, `word_out`=0, `frame_done`=0 throughout.
- **Full frame:** `CLK_DIV`=4, `GUARD_CYCLES`=1; `load` 0x12345678, then `enable`=1 →
  - anodes step 7F,BF,DF,EF,F7,FB,FD,FE with 4-cycle DRIVE and 1-cycle all-FF guard between;
  - segments 79,24,30,19,12,02,78,00;
  - `frame_done` pulses once every 40 cycles.
- **Tear-free load:** load 0xAAAAAAAA during digit 3 of a 0x12345678 frame → digits 3..7 still show 4..8; `word_out` switches at the next digit-0 GUARD entry, and digit 0 shows 08.
- **Simultaneous:** `load` 0xFFFFFFFF on the exact digit-0 GUARD entry edge → `word_out`=FFFFFFFF that cycle, and digit 0 segments=0E.
- **Enable drop:** deassert `enable` in DRIVE of digit 5 → `anodes`=FF next cycle; re-enable → restarts at digit 0 after `GUARD_CYCLES`.
- **Leading zero blank (with `LEADING_ZERO_BLANK_EN`):**
  - word 0x000000A0 → digits 0..5 have segments 7F while their anodes are asserted, digit 6=08, digit 7=40;
  - word 0 → only digit 7 shows 40.
